ex_muldiv_unit: RTL and testbench



---
 rtl/ex_muldiv_unit_if.sv | 27 ++
 rtl/ex_muldiv_unit.sv | 166 ++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_unit_if.sv
// rtl/ex_muldiv_unit_if.sv - request/result bundle between the EX stage and the mul/div unit
//
// start/op/A/B/flush : request side (driven by the pipeline, master)
// busy/done/hi/lo    : status and HI/LO results (driven by the unit, slave)
interface ex_muldiv_unit_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, A, B, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, A, B, flush,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset
//   bus   - slave side of ex_muldiv_unit_if:
//           start/op/A/B request, flush abort,
//           busy (state decode), done (one-cycle pulse), hi/lo registers
module ex_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    ex_muldiv_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CW-1:0]      count;
    // Multiply: {partial product high, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits shifting into quotient}.
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;      // multiplicand or divisor magnitude
    logic               is_div;
    logic               neg_q;     // negate product / quotient
    logic               neg_r;     // negate remainder
    logic               div_zero;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;

    logic               busy;
    logic               fix_write;
    logic               op_signed;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH+1:0]   div_diff;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; flush is ignored in IDLE so a coincident start wins
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (bus.start && !bus.op[2]) state_nxt = S_RUN;
            S_RUN: begin
                if (bus.flush) begin
                    state_nxt = S_IDLE;
                end else if (count == CW'(WIDTH - 1)) begin
                    state_nxt = S_FIX;
                end
            end
            S_FIX:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        busy      = (state != S_IDLE);
        fix_write = (state == S_FIX) && !bus.flush;
    end

    // Operand magnitudes; unsigned ops pass through untouched
    always_comb begin
        op_signed = ~bus.op[0];
        a_mag     = (op_signed && bus.A[WIDTH-1]) ? -bus.A : bus.A;
        b_mag     = (op_signed && bus.B[WIDTH-1]) ? -bus.B : bus.B;
    end

    // One iteration: shift-add for multiply, restoring step for divide.
    // On a failed trial subtract the remainder's top bit is always zero,
    // so a plain left shift of acc restores it.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        div_diff = {1'b0, acc[2*WIDTH-1:WIDTH-1]} - {2'b00, opnd};
        if (!is_div) begin
            acc_step = {mul_sum, acc[WIDTH-1:1]};
        end else if (div_diff[WIDTH+1]) begin
            acc_step = {acc[2*WIDTH-2:0], 1'b0};
        end else begin
            acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end
    end

    // Sign fix-up. Divide-by-zero leaves rem=|A|, which the remainder sign
    // turns back into A, so only the quotient needs forcing.
    always_comb begin
        prod = neg_q ? -acc : acc;
        quo  = div_zero ? '1 : (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
        rem  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    // Datapath and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count    <= '0;
            acc      <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= fix_write;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        case (bus.op)
                            3'b100: hi_q <= bus.A;
                            3'b101: lo_q <= bus.A;
                            3'b000, 3'b001, 3'b010, 3'b011: begin
                                is_div   <= bus.op[1];
                                neg_q    <= op_signed && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                                neg_r    <= op_signed && bus.A[WIDTH-1];
                                div_zero <= (bus.B == '0);
                                acc      <= {{WIDTH{1'b0}}, (bus.op[1] ? a_mag : b_mag)};
                                opnd     <= bus.op[1] ? b_mag : a_mag;
                                count    <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    acc   <= acc_step;
                    count <= count + 1'b1;
                end
                S_FIX: begin
                    if (fix_write) begin
                        hi_q <= is_div ? rem : prod[2*WIDTH-1:WIDTH];
                        lo_q <= is_div ? quo : prod[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = busy;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - directed self-checking bench for ex_muldiv_unit
module tb_ex_muldiv_unit;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    ex_muldiv_unit_if #(.WIDTH(32)) bus ();

    ex_muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; drive and sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue a request sampled at E0, return just after E33 (done cycle).
    task automatic go(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1; bus.op = op; bus.A = a; bus.B = b;
        step();
        bus.start = 1'b0;
        repeat (33) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0; bus.op = 3'b000; bus.A = '0; bus.B = '0; bus.flush = 1'b0;
        step(); step();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
        checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h exp 0", bus.hi); end
        checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h exp 0", bus.lo); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_mult();
        int busy_bad = 0;
        bus.start = 1'b1; bus.op = 3'b000; bus.A = 32'hFFFF_FFFD; bus.B = 32'd5;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 33; i++) begin
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) busy_bad++;
            if (i < 32) step();
        end
        checks++; if (busy_bad != 0) begin errors++; $display("FAIL mult_busy_window bad cycles %0d exp 0", busy_bad); end
        step();
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL mult_done got %b exp 1", bus.done); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mult_busy_end got %b exp 0", bus.busy); end
        checks++; if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h exp ffffffff", bus.hi); end
        checks++; if (bus.lo !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mult_lo got %h exp fffffff1", bus.lo); end
        step();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL mult_done_width got %b exp 0", bus.done); end
    endtask

    task automatic test_multu_divu();
        go(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checks++; if (bus.hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi got %h exp fffffffe", bus.hi); end
        checks++; if (bus.lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo got %h exp 00000001", bus.lo); end
        go(3'b011, 32'd100, 32'd7);
        checks++; if (bus.lo !== 32'd14) begin errors++; $display("FAIL divu_lo got %h exp 0000000e", bus.lo); end
        checks++; if (bus.hi !== 32'd2) begin errors++; $display("FAIL divu_hi got %h exp 00000002", bus.hi); end
    endtask

    task automatic test_div();
        go(3'b010, 32'hFFFF_FFF9, 32'd2);
        checks++; if (bus.lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_lo got %h exp fffffffd", bus.lo); end
        checks++; if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg_hi got %h exp ffffffff", bus.hi); end
        go(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        checks++; if (bus.lo !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo got %h exp 80000000", bus.lo); end
        checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL div_ovf_hi got %h exp 00000000", bus.hi); end
        go(3'b010, 32'h1234, 32'h0);
        checks++; if (bus.lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_zero_lo got %h exp ffffffff", bus.lo); end
        checks++; if (bus.hi !== 32'h1234) begin errors++; $display("FAIL div_zero_hi got %h exp 00001234", bus.hi); end
        go(3'b011, 32'h1234, 32'h0);
        checks++; if (bus.lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_zero_lo got %h exp ffffffff", bus.lo); end
        checks++; if (bus.hi !== 32'h1234) begin errors++; $display("FAIL divu_zero_hi got %h exp 00001234", bus.hi); end
    endtask

    task automatic test_mt();
        bus.start = 1'b1; bus.op = 3'b100; bus.A = 32'hAAAA_5555;
        step();
        checks++; if (bus.hi !== 32'hAAAA_5555) begin errors++; $display("FAIL mthi_hi got %h exp aaaa5555", bus.hi); end
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL mthi_status got busy=%b done=%b exp 0/0", bus.busy, bus.done); end
        bus.op = 3'b101; bus.A = 32'h1;
        step();
        bus.start = 1'b0;
        checks++; if (bus.lo !== 32'h1) begin errors++; $display("FAIL mtlo_lo got %h exp 00000001", bus.lo); end
        checks++; if (bus.hi !== 32'hAAAA_5555) begin errors++; $display("FAIL mtlo_hi_hold got %h exp aaaa5555", bus.hi); end
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL mtlo_status got busy=%b done=%b exp 0/0", bus.busy, bus.done); end
        bus.start = 1'b1; bus.op = 3'b110; bus.A = 32'hDEAD_BEEF;
        step();
        bus.start = 1'b0;
        checks++; if (bus.hi !== 32'hAAAA_5555 || bus.lo !== 32'h1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL nop_op got hi=%h lo=%h busy=%b exp aaaa5555/00000001/0", bus.hi, bus.lo, bus.busy); end
    endtask

    task automatic test_back_to_back();
        bus.start = 1'b1; bus.op = 3'b000; bus.A = 32'd6; bus.B = 32'd7;
        step();
        bus.start = 1'b0;
        repeat (9) step();
        bus.start = 1'b1; bus.op = 3'b011; bus.A = 32'd100; bus.B = 32'd7;
        step();
        bus.start = 1'b0;
        repeat (23) step();
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL ign_done got %b exp 1", bus.done); end
        checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'd42) begin errors++; $display("FAIL ign_result got hi=%h lo=%h exp 0/2a", bus.hi, bus.lo); end
        // new request accepted in the done cycle
        go(3'b001, 32'd3, 32'd4);
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL b2b_done got %b exp 1", bus.done); end
        checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'd12) begin errors++; $display("FAIL b2b_result got hi=%h lo=%h exp 0/c", bus.hi, bus.lo); end
    endtask

    task automatic test_flush_reset();
        int done_seen = 0;
        bus.start = 1'b1; bus.op = 3'b100; bus.A = 32'h11; step();
        bus.op = 3'b101; bus.A = 32'h22; step();
        bus.start = 1'b1; bus.op = 3'b010; bus.A = 32'd100; bus.B = 32'd7;
        step();
        bus.start = 1'b0;
        repeat (14) step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b exp 0", bus.busy); end
        for (int i = 0; i < 25; i++) begin
            if (bus.done !== 1'b0) done_seen++;
            step();
        end
        checks++; if (done_seen != 0) begin errors++; $display("FAIL flush_no_done got %0d pulses exp 0", done_seen); end
        checks++; if (bus.hi !== 32'h11 || bus.lo !== 32'h22) begin errors++; $display("FAIL flush_hold got hi=%h lo=%h exp 11/22", bus.hi, bus.lo); end
        // start and flush together in IDLE: start wins
        bus.start = 1'b1; bus.flush = 1'b1; bus.op = 3'b000; bus.A = 32'd5; bus.B = 32'd5;
        step();
        bus.start = 1'b0; bus.flush = 1'b0;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL start_over_flush got busy=%b exp 1", bus.busy); end
        repeat (10) step();
        rst_n = 1'b0;
        step();
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL midrst_status got busy=%b done=%b exp 0/0", bus.busy, bus.done); end
        checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin errors++; $display("FAIL midrst_regs got hi=%h lo=%h exp 0/0", bus.hi, bus.lo); end
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) done_seen++;
        end
        checks++; if (done_seen != 0) begin errors++; $display("FAIL midrst_quiet got %0d active cycles exp 0", done_seen); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.op = '0; bus.A = '0; bus.B = '0; bus.flush = 1'b0;
        test_reset();
        test_mult();
        test_multu_divu();
        test_div();
        test_mt();
        test_back_to_back();
        test_flush_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
